// File: rtl/axi_write_arbiter.sv
// Write-path arbiter: grants one AXI write transaction at a time across NUM_M masters,
// holding the AW/W/B mux routing from the AW handshake through WLAST to the B handshake.
module axi_write_arbiter #(
  parameter int NUM_M = 3,
  parameter int NUM_S = 6,
  parameter int SW    = 3,
  parameter int BEATW = 8
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [NUM_M-1:0]    AWVALID_M,
  input  logic [NUM_M*SW-1:0] AWTARGET_M,
  input  logic [NUM_S:0]      AWREADY_S,
  input  logic                aw_hs,
  input  logic                w_hs,
  input  logic                wlast,
  input  logic                b_hs,
  output logic [1:0]          W_M,
  output logic [SW-1:0]       W_S,
  output logic                aw_en,
  output logic                w_en,
  output logic                b_en,
  output logic [BEATW-1:0]    beat_cnt,
  output logic                busy
);

  localparam int MW = 2;
  localparam logic [MW-1:0] M_NONE = '1;
  localparam logic [SW-1:0] S_NONE = '1;
  localparam logic [SW-1:0] S_DEF  = SW'(NUM_S);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  state_e           state_q, state_d;
  logic [MW-1:0]    w_m_q, w_m_d;
  logic [SW-1:0]    w_s_q, w_s_d;
  logic [BEATW-1:0] beat_q, beat_d;
  logic [MW-1:0]    last_q, last_d;
  logic             aw_en_q, aw_en_d;
  logic             w_en_q, w_en_d;
  logic             b_en_q, b_en_d;
  logic             busy_q, busy_d;

  // Out-of-range targets are routed to the default (decode-error) slave.
  logic [SW-1:0]    tgt_dec [NUM_M];
  logic [NUM_M-1:0] elig;

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      tgt_dec[m] = (AWTARGET_M[m*SW +: SW] >= S_DEF) ? S_DEF : AWTARGET_M[m*SW +: SW];
      elig[m]    = AWVALID_M[m] & AWREADY_S[tgt_dec[m]];
    end
  end

  logic          win_found;
  logic [MW-1:0] win_m;
  logic [SW-1:0] win_s;

  // Round-robin scan starting just after the last served master.
  always_comb begin : arb
    logic [MW-1:0] cand;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_m     = M_NONE;
    win_s     = S_NONE;
    cand      = '0;
    for (int i = 1; i <= NUM_M; i++) begin
      cand = MW'((int'(last_q) + i) % NUM_M);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_m     = cand;
        win_s     = tgt_dec[cand];
      end
    end
  end

  // State register: all control and output state lives here.
  // NOTE: the asynchronous reset returns every register, including last_q, to its initial value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      w_m_q   <= M_NONE;
      w_s_q   <= S_NONE;
      beat_q  <= '0;
      last_q  <= MW'(NUM_M - 1);
      aw_en_q <= 1'b0;
      w_en_q  <= 1'b0;
      b_en_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q <= state_d;
      w_m_q   <= w_m_d;
      w_s_q   <= w_s_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      aw_en_q <= aw_en_d;
      w_en_q  <= w_en_d;
      b_en_q  <= b_en_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; handshakes outside their own phase fall through untouched.
  always_comb begin
    state_d = state_q;
    w_m_d   = w_m_q;
    w_s_d   = w_s_q;
    beat_d  = beat_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_AW;
          w_m_d   = win_m;
          w_s_d   = win_s;
          beat_d  = '0;
        end
      end
      ST_AW: begin
        if (aw_hs) state_d = ST_W;
      end
      ST_W: begin
        if (w_hs) begin
          beat_d = beat_q + BEATW'(1);
          if (wlast) state_d = ST_B;
        end
      end
      ST_B: begin
        if (b_hs) begin
          last_d  = w_m_q;
          w_m_d   = M_NONE;
          w_s_d   = S_NONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: enables are decoded from the next state and registered.
  always_comb begin
    aw_en_d = (state_d == ST_AW);
    w_en_d  = (state_d == ST_W);
    b_en_d  = (state_d == ST_B);
    busy_d  = (state_d != ST_IDLE);
  end

  assign W_M      = w_m_q;
  assign W_S      = w_s_q;
  assign aw_en    = aw_en_q;
  assign w_en     = w_en_q;
  assign b_en     = b_en_q;
  assign beat_cnt = beat_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Self-checking bench for axi_write_arbiter: a table of single-burst grants checked through
// a grant scoreboard, plus hand-written sequences for stray handshakes and mid-burst reset.
module tb_axi_write_arbiter;

  localparam int NUM_M = 3;
  localparam int NUM_S = 6;
  localparam int SW    = 3;
  localparam int BEATW = 8;

  logic                ACLK = 1'b0;
  logic                ARESETn;
  logic [NUM_M-1:0]    AWVALID_M;
  logic [NUM_M*SW-1:0] AWTARGET_M;
  logic [NUM_S:0]      AWREADY_S;
  logic                aw_hs, w_hs, wlast, b_hs;
  logic [1:0]          W_M;
  logic [SW-1:0]       W_S;
  logic                aw_en, w_en, b_en, busy;
  logic [BEATW-1:0]    beat_cnt;

  always #5 ACLK = ~ACLK;

  axi_write_arbiter #(.NUM_M(NUM_M), .NUM_S(NUM_S), .SW(SW), .BEATW(BEATW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID_M(AWVALID_M), .AWTARGET_M(AWTARGET_M), .AWREADY_S(AWREADY_S),
    .aw_hs(aw_hs), .w_hs(w_hs), .wlast(wlast), .b_hs(b_hs),
    .W_M(W_M), .W_S(W_S), .aw_en(aw_en), .w_en(w_en), .b_en(b_en),
    .beat_cnt(beat_cnt), .busy(busy)
  );

  typedef struct {
    logic [2:0] awvalid;
    logic [8:0] tgt;
    logic [6:0] awready;
    int         beats;
    logic [1:0] exp_m;
    logic [2:0] exp_s;
    int         exp_wait;
    logic [2:0] keep;
  } vec_t;

  typedef struct {
    logic [1:0] m;
    logic [2:0] s;
  } grant_t;

  grant_t sb[$];
  vec_t   vecs[8];
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_grant(input string tag, input int exp_wait);
    grant_t g;
    int     waited;
    bit     ok;
    waited = 0;
    ok     = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge ACLK);
      if (aw_en === 1'b1) ok = 1'b1;
      else waited++;
    end
    check({tag, "_grant_seen"}, 32'(ok), 32'd1);
    if (sb.size() > 0) begin
      g = sb.pop_front();
      check({tag, "_W_M"}, 32'(W_M), 32'(g.m));
      check({tag, "_W_S"}, 32'(W_S), 32'(g.s));
    end
    check({tag, "_busy"}, 32'(busy), 32'd1);
    if (exp_wait >= 0) check({tag, "_idle_wait"}, 32'(waited), 32'(exp_wait));
  endtask

  task automatic run_burst(input string tag, input int beats);
    aw_hs = 1'b1;
    @(negedge ACLK);
    aw_hs = 1'b0;
    check({tag, "_w_en"}, 32'({aw_en, w_en, b_en}), 32'b010);
    for (int b = 0; b < beats; b++) begin
      w_hs  = 1'b1;
      wlast = (b == beats - 1);
      @(negedge ACLK);
      if (b != beats - 1) check({tag, "_beat_mid"}, 32'({w_en, beat_cnt}), 32'({1'b1, 8'(b + 1)}));
    end
    w_hs  = 1'b0;
    wlast = 1'b0;
    check({tag, "_b_en"}, 32'({aw_en, w_en, b_en}), 32'b001);
    check({tag, "_beat_cnt"}, 32'(beat_cnt), 32'(beats));
    b_hs = 1'b1;
    @(negedge ACLK);
    b_hs = 1'b0;
    check({tag, "_done_W_M"}, 32'(W_M), 32'h3);
    check({tag, "_done_W_S"}, 32'(W_S), 32'h7);
    check({tag, "_done_idle"}, 32'({busy, aw_en, w_en, b_en}), 32'h0);
  endtask

  initial begin
    // Round-robin sweep, eligibility masking, default-slave decode, priority rotation.
    vecs[0] = '{3'b111, 9'o111, 7'h7F, 2, 2'd0, 3'd1, 0, 3'b111};
    vecs[1] = '{3'b111, 9'o111, 7'h7F, 1, 2'd1, 3'd1, 0, 3'b111};
    vecs[2] = '{3'b111, 9'o111, 7'h7F, 3, 2'd2, 3'd1, 0, 3'b000};
    vecs[3] = '{3'b101, 9'o502, 7'b1111011, 2, 2'd2, 3'd5, 0, 3'b001};
    vecs[4] = '{3'b001, 9'o502, 7'h7F, 3, 2'd0, 3'd2, 0, 3'b000};
    vecs[5] = '{3'b010, 9'o040, 7'h7F, 4, 2'd1, 3'd4, 0, 3'b000};
    vecs[6] = '{3'b001, 9'o007, 7'h7F, 1, 2'd0, 3'd6, 0, 3'b000};
    vecs[7] = '{3'b101, 9'o603, 7'h7F, 2, 2'd2, 3'd6, 0, 3'b000};

    ARESETn    = 1'b0;
    AWVALID_M  = '0;
    AWTARGET_M = '0;
    AWREADY_S  = '1;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    wlast      = 1'b0;
    b_hs       = 1'b0;
    repeat (2) @(negedge ACLK);
    check("rst_W_M", 32'(W_M), 32'h3);
    check("rst_W_S", 32'(W_S), 32'h7);
    check("rst_flags", 32'({busy, aw_en, w_en, b_en}), 32'h0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("idle_no_req", 32'(busy), 32'h0);

    for (int i = 0; i < 8; i++) begin
      string tag;
      grant_t g;
      tag        = $sformatf("vec%0d", i);
      AWVALID_M  = vecs[i].awvalid;
      AWTARGET_M = vecs[i].tgt;
      AWREADY_S  = vecs[i].awready;
      g.m = vecs[i].exp_m;
      g.s = vecs[i].exp_s;
      sb.push_back(g);
      expect_grant(tag, vecs[i].exp_wait);
      AWVALID_M = vecs[i].keep;
      run_burst(tag, vecs[i].beats);
    end
    AWVALID_M = '0;

    // Stray handshakes in AW and W must not move state or the beat counter.
    begin
      grant_t g;
      AWVALID_M  = 3'b010;
      AWTARGET_M = 9'o030;
      g.m = 2'd1;
      g.s = 3'd3;
      sb.push_back(g);
      expect_grant("ign", 0);
      AWVALID_M = '0;
      w_hs  = 1'b1;
      wlast = 1'b1;
      b_hs  = 1'b1;
      @(negedge ACLK);
      w_hs  = 1'b0;
      wlast = 1'b0;
      b_hs  = 1'b0;
      check("ign_aw_state", 32'({aw_en, w_en, b_en, beat_cnt}), 32'({3'b100, 8'd0}));
      aw_hs = 1'b1;
      @(negedge ACLK);
      aw_hs = 1'b0;
      w_hs  = 1'b1;
      @(negedge ACLK);
      w_hs = 1'b0;
      check("ign_first_beat", 32'({w_en, beat_cnt}), 32'({1'b1, 8'd1}));
      for (int k = 0; k < 4; k++) begin
        AWVALID_M = (k % 2 == 1) ? 3'b111 : 3'b000;
        aw_hs = 1'b1;
        b_hs  = 1'b1;
        wlast = 1'b1;
        @(negedge ACLK);
        check($sformatf("ign_w_hold%0d", k), 32'({aw_en, w_en, b_en, beat_cnt}),
              32'({3'b010, 8'd1}));
        check($sformatf("ign_route%0d", k), 32'({W_M, W_S}), 32'({2'd1, 3'd3}));
      end
      AWVALID_M = '0;
      aw_hs = 1'b0;
      b_hs  = 1'b0;
      w_hs  = 1'b1;
      wlast = 1'b1;
      @(negedge ACLK);
      w_hs  = 1'b0;
      wlast = 1'b0;
      check("ign_to_b", 32'({b_en, beat_cnt}), 32'({1'b1, 8'd2}));
      b_hs = 1'b1;
      @(negedge ACLK);
      b_hs = 1'b0;
      check("ign_done", 32'({busy, W_M, W_S}), 32'({1'b0, 2'h3, 3'h7}));
    end

    // Reset mid-burst clears everything at once and restores M0 priority.
    begin
      grant_t g;
      AWVALID_M  = 3'b100;
      AWTARGET_M = '0;
      g.m = 2'd2;
      g.s = 3'd0;
      sb.push_back(g);
      expect_grant("mid_rst", 0);
      AWVALID_M = '0;
      aw_hs = 1'b1;
      @(negedge ACLK);
      aw_hs = 1'b0;
      w_hs  = 1'b1;
      repeat (2) @(negedge ACLK);
      w_hs = 1'b0;
      check("mid_rst_beats", 32'({w_en, beat_cnt}), 32'({1'b1, 8'd2}));
      AWVALID_M = 3'b111;
      ARESETn   = 1'b0;
      #1;
      check("mid_rst_route", 32'({W_M, W_S}), 32'({2'h3, 3'h7}));
      check("mid_rst_flags", 32'({busy, aw_en, w_en, b_en, beat_cnt}), 32'h0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      g.m = 2'd0;
      g.s = 3'd0;
      sb.push_back(g);
      expect_grant("post_rst", 0);
      AWVALID_M = '0;
      run_burst("post_rst", 1);
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
